// File: rtl/pc_pkg.sv
// Shared definitions for the program counter / return-address stack slice.
// Command encoding reflects single-cycle strobe priority (higher value wins).
package pc_pkg;

  typedef enum logic [2:0] {
    CMD_NONE = 3'd0,
    CMD_INC  = 3'd1,
    CMD_REL  = 3'd2,
    CMD_LOAD = 3'd3,
    CMD_CALL = 3'd4,
    CMD_RET  = 3'd5
  } cmd_e;

  // Ceiling log2 for elaboration-time width sizing; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: LIFO register file with a pointer that spans 0..STACK_DEPTH.
// Overflow/underflow requests are silently ignored; the parent owns error reporting.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned STACK_DEPTH = 4,
  localparam int unsigned IDX_W      = clog2(STACK_DEPTH),
  localparam int unsigned SP_W       = clog2(STACK_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic [SP_W-1:0]   sp
);

  logic [ADDR_W-1:0] mem [STACK_DEPTH];
  logic [SP_W-1:0]   sp_m1;
  logic              do_push;
  logic              do_pop;

  assign empty   = (sp == '0);
  assign full    = (sp == SP_W'(STACK_DEPTH));
  assign sp_m1   = sp - SP_W'(1);
  assign dout    = mem[sp_m1[IDX_W-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && !pop && !full;

  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= '0;
    end else if (do_pop) begin
      sp <= sp_m1;
    end else if (do_push) begin
      sp <= sp + SP_W'(1);
    end
  end

  // Entries carry no reset; only slots below sp are ever read meaningfully.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[sp[IDX_W-1:0]] <= din;
    end
  end

endmodule

// File: rtl/pc_stack_unit.sv
// Parametrised program counter with increment, load, call/return via pc_ras.
// Optional PC-relative branch input PC_rel is enabled by defining PC_RELBR_EN.
module pc_stack_unit
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 8,
  parameter int unsigned       STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PC_in,
  input  logic              PC_out,
  input  logic              PC_inc,
  input  logic              PC_call,
  input  logic              PC_ret,
`ifdef PC_RELBR_EN
  input  logic              PC_rel,
`endif
  input  logic [ADDR_W-1:0] data_in,
  output logic [ADDR_W-1:0] data_out,
  output logic [ADDR_W-1:0] pc_q,
  output logic              stk_empty,
  output logic              stk_full,
  output logic              stk_err
);

  localparam int unsigned SP_W = clog2(STACK_DEPTH) + 1;

  cmd_e              cmd;
  logic              rel_req;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] pc_rel_sum;
  logic              ras_push;
  logic              ras_pop;
  logic              err_set;
  logic [ADDR_W-1:0] ras_dout;
  logic              ras_empty;
  logic              ras_full;
  logic [SP_W-1:0]   ras_sp;

`ifdef PC_RELBR_EN
  assign rel_req = PC_rel;
`else
  assign rel_req = 1'b0;
`endif

  // Width-matched add: sign extension of data_in is implicit modulo 2^ADDR_W.
  assign pc_plus1   = ADDR_W'(pc_q + ADDR_W'(1));
  assign pc_rel_sum = ADDR_W'(pc_q + data_in);

  // Strobe priority: ret > call > load > rel > inc.
  always_comb begin
    cmd = CMD_NONE;
    if (PC_ret)       cmd = CMD_RET;
    else if (PC_call) cmd = CMD_CALL;
    else if (PC_in)   cmd = CMD_LOAD;
    else if (rel_req) cmd = CMD_REL;
    else if (PC_inc)  cmd = CMD_INC;
  end

  always_comb begin
    pc_next  = pc_q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    err_set  = 1'b0;
    case (cmd)
      CMD_INC:  pc_next = pc_plus1;
      CMD_REL:  pc_next = pc_rel_sum;
      CMD_LOAD: pc_next = data_in;
      CMD_CALL: begin
        if (ras_full) begin
          err_set = 1'b1;
        end else begin
          ras_push = 1'b1;
          pc_next  = data_in;
        end
      end
      CMD_RET: begin
        if (ras_empty) begin
          err_set = 1'b1;
        end else begin
          ras_pop = 1'b1;
          pc_next = ras_dout;
        end
      end
      default: pc_next = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_VEC;
      data_out <= '0;
      stk_err  <= 1'b0;
    end else begin
      pc_q <= pc_next;
      if (PC_out) data_out <= pc_next;
      if (err_set) stk_err <= 1'b1;
    end
  end

  pc_ras #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (pc_plus1),
    .dout  (ras_dout),
    .empty (ras_empty),
    .full  (ras_full),
    .sp    (ras_sp)
  );

  assign stk_empty = (ras_sp == '0);
  assign stk_full  = (ras_sp == SP_W'(STACK_DEPTH));

endmodule
